// File: rtl/esc_array.sv
// N-channel frame-synchronous ESC pulse generator with arming, motors_off override and shadowed speeds.
// Optional build macro ESC_SLEW_EN: rate-limit upward/downward speed changes to SLEW_STEP per frame.
module esc_array #(
  parameter int NUM_MOTORS = 4,
  parameter int SPD_W      = 11,
  parameter int PERIOD     = 125000,
  parameter int PERIOD_W   = 17,
  parameter int OFF_PULSE  = 50000,
  parameter int SCALE_SH   = 4,
  parameter int ARM_FRAMES = 8,
  parameter int SLEW_STEP  = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MOTORS*SPD_W-1:0] spd,
  input  logic                        motors_off,
  input  logic                        arm,
  input  logic                        disarm,
  output logic [NUM_MOTORS-1:0]       pwm,
  output logic                        armed,
  output logic                        frame_strt
);

  localparam int AF_W = $clog2(ARM_FRAMES + 1);

  // The widest possible pulse must still leave a low gap inside the frame.
  if ((longint'(OFF_PULSE) + (((longint'(1) << SPD_W) - 1) << SCALE_SH)) >= longint'(PERIOD)) begin : g_bad_width
    $error("esc_array: OFF_PULSE + (max speed << SCALE_SH) must be below PERIOD");
  end
  if ((longint'(1) << PERIOD_W) < longint'(PERIOD)) begin : g_bad_cnt
    $error("esc_array: PERIOD_W too narrow for PERIOD");
  end
  if (ARM_FRAMES < 1 || SLEW_STEP < 1) begin : g_bad_cfg
    $error("esc_array: ARM_FRAMES and SLEW_STEP must be at least 1");
  end

  typedef enum logic [1:0] {DISARMED, ARMING, ARMED} state_t;

  state_t                      state_reg;
  logic [PERIOD_W-1:0]         cnt_reg;
  logic [AF_W-1:0]             arm_cnt_reg;
  logic                        dis_pend_reg;
  logic [NUM_MOTORS*SPD_W-1:0] app_reg;
  logic [NUM_MOTORS*SPD_W-1:0] app_next;
  logic [NUM_MOTORS-1:0]       pwm_next;

  logic bnd;
  logic go_dis;
  logic force_zero;

  assign bnd        = (cnt_reg == PERIOD_W'(PERIOD - 1));
  assign go_dis     = (state_reg != DISARMED) && (dis_pend_reg || disarm);
  // A channel that will not be armed next frame is parked at zero with no slew.
  assign force_zero = motors_off || (state_reg != ARMED) || go_dis;

  for (genvar gi = 0; gi < NUM_MOTORS; gi++) begin : g_ch
    logic [SPD_W-1:0]    tgt;
    logic [SPD_W-1:0]    cur;
    logic [SPD_W-1:0]    step_val;
    logic [PERIOD_W-1:0] pw;

    assign tgt = spd[gi*SPD_W +: SPD_W];
    assign cur = app_reg[gi*SPD_W +: SPD_W];

`ifdef ESC_SLEW_EN
    logic             up;
    logic [SPD_W-1:0] diff;
    assign up       = (tgt > cur);
    assign diff     = up ? (tgt - cur) : (cur - tgt);
    assign step_val = (int'(diff) <= SLEW_STEP) ? tgt :
                      up ? (cur + SPD_W'(SLEW_STEP)) : (cur - SPD_W'(SLEW_STEP));
`else
    assign step_val = tgt;
`endif

    assign app_next[gi*SPD_W +: SPD_W] = force_zero ? '0 : step_val;
    assign pw           = PERIOD_W'(OFF_PULSE) + (PERIOD_W'(cur) << SCALE_SH);
    assign pwm_next[gi] = (cnt_reg < pw) && (state_reg != DISARMED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      state_reg    <= DISARMED;
      arm_cnt_reg  <= '0;
      dis_pend_reg <= 1'b0;
      app_reg      <= '0;
      pwm          <= '0;
      armed        <= 1'b0;
      frame_strt   <= 1'b0;
    end else begin
      cnt_reg    <= bnd ? '0 : cnt_reg + 1'b1;
      pwm        <= pwm_next;
      frame_strt <= (cnt_reg == '0);
      if (bnd) begin
        app_reg <= app_next;
      end

      case (state_reg)
        DISARMED: begin
          if (arm && !disarm) begin
            state_reg   <= ARMING;
            arm_cnt_reg <= '0;
          end
        end
        ARMING, ARMED: begin
          // Disarm is deferred to the frame boundary so no pulse is cut short.
          if (bnd && go_dis) begin
            state_reg    <= DISARMED;
            dis_pend_reg <= 1'b0;
            armed        <= 1'b0;
          end else begin
            if (disarm) begin
              dis_pend_reg <= 1'b1;
            end
            if (state_reg == ARMING && bnd) begin
              if (arm_cnt_reg == AF_W'(ARM_FRAMES - 1)) begin
                state_reg <= ARMED;
                armed     <= 1'b1;
              end else begin
                arm_cnt_reg <= arm_cnt_reg + 1'b1;
              end
            end
          end
        end
        default: begin
          state_reg <= DISARMED;
          armed     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_esc_array.sv
// Directed bench for esc_array with shortened frames; measures each channel's
// pulse width per frame and compares against hand-computed widths.
module tb_esc_array;
  localparam int NM   = 4;
  localparam int SW   = 4;
  localparam int PER  = 200;
  localparam int PW   = 8;
  localparam int OFF  = 50;
  localparam int SH   = 2;
  localparam int AF   = 3;
  localparam int STEP = 3;

  logic             clk;
  logic             rst;
  logic [NM*SW-1:0] spd;
  logic             motors_off;
  logic             arm;
  logic             disarm;
  logic [NM-1:0]    pwm;
  logic             armed;
  logic             frame_strt;

  int total;
  int bad;
  int acc [NM];
  int last_w [NM];
  int frames_seen;
  int per_cnt;
  int last_period;

  esc_array #(
    .NUM_MOTORS(NM), .SPD_W(SW), .PERIOD(PER), .PERIOD_W(PW),
    .OFF_PULSE(OFF), .SCALE_SH(SH), .ARM_FRAMES(AF), .SLEW_STEP(STEP)
  ) dut (
    .clk(clk), .rst(rst), .spd(spd), .motors_off(motors_off),
    .arm(arm), .disarm(disarm), .pwm(pwm), .armed(armed), .frame_strt(frame_strt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-frame width monitor: on each frame_strt the previous frame's widths are latched.
  always @(negedge clk) begin
    if (rst) begin
      frames_seen <= 0;
      per_cnt     <= 0;
      last_period <= 0;
      for (int i = 0; i < NM; i++) begin
        acc[i]    <= 0;
        last_w[i] <= 0;
      end
    end else if (frame_strt) begin
      frames_seen <= frames_seen + 1;
      last_period <= per_cnt;
      per_cnt     <= 1;
      for (int i = 0; i < NM; i++) begin
        last_w[i] <= acc[i];
        acc[i]    <= int'(pwm[i]);
      end
    end else begin
      per_cnt <= per_cnt + 1;
      for (int i = 0; i < NM; i++) begin
        acc[i] <= acc[i] + int'(pwm[i]);
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_w(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e [NM];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    $display("frame %0d %s widths %0d %0d %0d %0d armed=%0d", frames_seen, tag,
             last_w[0], last_w[1], last_w[2], last_w[3], armed);
    for (int i = 0; i < NM; i++) begin
      check($sformatf("%s_ch%0d", tag, i), last_w[i], e[i]);
    end
  endtask

  // Returns at negedge+1 of the first cycle of the next frame (cnt==1 inside the DUT).
  task automatic wait_frame();
    int target;
    bit seen;
    target = frames_seen + 1;
    seen = 1'b0;
    for (int k = 0; k < 3 * PER; k++) begin
      @(negedge clk);
      #1;
      if (frames_seen >= target) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("frame_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_arm_disarm(input logic a, input logic d);
    arm = a;
    disarm = d;
    idle(1);
    arm = 1'b0;
    disarm = 1'b0;
  endtask

  initial begin
    int sl [4];
    total = 0;
    bad = 0;
    rst = 1'b1;
    spd = '0;
    motors_off = 1'b0;
    arm = 1'b0;
    disarm = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_frame_strt", int'(frame_strt), 0);
    rst = 1'b0;

    // Idle frames while disarmed.
    wait_frame();
    for (int f = 0; f < 3; f++) begin
      wait_frame();
      chk_w("idle", 0, 0, 0, 0);
      check("idle_armed", int'(armed), 0);
      check("idle_period", last_period, PER);
    end

    // Arm late in the frame so the partial frame carries no pulse.
    idle(100);
    spd = {4'd5, 4'd5, 4'd5, 4'd5};
    pulse_arm_disarm(1'b1, 1'b0);
    wait_frame(); chk_w("arm_partial", 0, 0, 0, 0);  check("arm0_armed", int'(armed), 0);
    wait_frame(); chk_w("arming1", 50, 50, 50, 50);  check("arm1_armed", int'(armed), 0);
    wait_frame(); chk_w("arming2", 50, 50, 50, 50);  check("arm2_armed", int'(armed), 1);
    wait_frame(); chk_w("armed_first", 50, 50, 50, 50);
    spd = {4'd9, 4'd5, 4'd0, 4'd15};
    wait_frame(); chk_w("spd5", 70, 70, 70, 70);
    wait_frame(); chk_w("spd_mix", 110, 50, 70, 86);
    idle(80);
    spd = {4'd9, 4'd5, 4'd7, 4'd2};
    wait_frame(); chk_w("mid_change_held", 110, 50, 70, 86);
    wait_frame(); chk_w("mid_change_new", 58, 78, 70, 86);
    idle(80);
    motors_off = 1'b1;
    wait_frame(); chk_w("moff_held", 58, 78, 70, 86);
    wait_frame(); chk_w("moff_off", 50, 50, 50, 50);
    check("moff_armed", int'(armed), 1);

    // Disarm while a pulse is high: it must complete.
    motors_off = 1'b0;
    idle(5);
    pulse_arm_disarm(1'b0, 1'b1);
    wait_frame(); chk_w("disarm_complete", 50, 50, 50, 50);
    check("disarm_armed", int'(armed), 0);
    wait_frame(); chk_w("disarmed", 0, 0, 0, 0);

    // Simultaneous arm and disarm while disarmed: disarm wins.
    idle(100);
    pulse_arm_disarm(1'b1, 1'b1);
    for (int f = 0; f < 5; f++) begin
      wait_frame();
      chk_w("arm_disarm", 0, 0, 0, 0);
      check("arm_disarm_armed", int'(armed), 0);
    end

    // Re-arm at speed 0, then step to 10 (slewed when ESC_SLEW_EN is defined).
`ifdef ESC_SLEW_EN
    sl[0] = 62; sl[1] = 74; sl[2] = 86; sl[3] = 90;
`else
    sl[0] = 90; sl[1] = 90; sl[2] = 90; sl[3] = 90;
`endif
    idle(100);
    spd = '0;
    pulse_arm_disarm(1'b1, 1'b0);
    wait_frame();
    wait_frame();
    wait_frame(); check("rearm_armed", int'(armed), 1);
    wait_frame(); chk_w("rearm_first", 50, 50, 50, 50);
    spd = {4'd10, 4'd10, 4'd10, 4'd10};
    wait_frame(); chk_w("slew_start", 50, 50, 50, 50);
    for (int f = 0; f < 4; f++) begin
      wait_frame();
      chk_w($sformatf("slew%0d", f), sl[f], sl[f], sl[f], sl[f]);
    end
    motors_off = 1'b1;
    wait_frame(); chk_w("slew_moff_held", 90, 90, 90, 90);
    wait_frame(); chk_w("slew_moff_off", 50, 50, 50, 50);
    check("slew_moff_armed", int'(armed), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/esc_array.md
Name: esc_array

Overview:
N-channel ESC PWM generator, the parametrised successor to the fixed four-motor ESC block driven by flght_cntrl. It converts per-motor speed words into frame-synchronous servo-style pulses, with an arming sequence, a motors_off override and glitch-free shadowed updates. One instance drives the airframe's motor outputs: NUM_MOTORS=4 for the quad, 6 or 8 for hex/octo builds.

Parameters:
NUM_MOTORS, 4, number of motor channels
SPD_W, 11, width of each speed word
PERIOD, 125000, frame length in clk cycles (400 Hz at 50 MHz)
PERIOD_W, 17, counter width; must satisfy 2^PERIOD_W >= PERIOD
OFF_PULSE, 50000, pulse width in cycles at speed 0 (1 ms)
SCALE_SH, 4, left shift applied to speed before adding to OFF_PULSE
ARM_FRAMES, 8, frames of OFF_PULSE sent during arming
SLEW_STEP, 64, max speed change per frame (only with ESC_SLEW_EN)

Ports:
clk  in  1  system clock
rst  in  1  reset. One clock; reset is synchronous and active-high.
spd  in  NUM_MOTORS*SPD_W  packed target speeds; channel i = spd[i*SPD_W +: SPD_W]
motors_off  in  1  force every channel to OFF_PULSE
arm  in  1  single-cycle request to start arming
disarm  in  1  single-cycle request to disarm
pwm  out  NUM_MOTORS  registered PWM outputs, active high
armed  out  1  high while in ARMED
frame_strt  out  1  one-cycle pulse coincident with the first cycle of each frame's pulses

Behaviour:
- Reset: cnt=0, state=DISARMED, shadow and applied speeds=0, frame counter=0; pwm=0, armed=0, frame_strt=0.
- Frame counter cnt runs 0..PERIOD-1 and wraps to 0. It free-runs in every state.
- Pulse width per channel: pw_i = OFF_PULSE + (applied_i << SCALE_SH), computed at PERIOD_W bits. Parameters must satisfy OFF_PULSE + ((2^SPD_W-1) << SCALE_SH) < PERIOD; add an elaboration-time check.
- Output: pwm[i] <= (cnt < pw_i) && (state != DISARMED). This is registered, so pwm is high for exactly pw_i consecutive cycles. frame_strt <= (cnt == 0).
- Shadow update happens only at the frame boundary (cnt == PERIOD-1). On that cycle, applied_i is loaded from spd, or 0 when motors_off=1 or state=ARMING. Mid-frame changes to spd or motors_off never alter the frame in progress.
- States:
  - DISARMED: pwm held low. arm=1 -> ARMING and the frame counter clears.
  - ARMING: OFF_PULSE on all channels. Frame counter increments at each boundary; after ARM_FRAMES boundaries -> ARMED.
  - ARMED: normal operation; armed=1.
- disarm=1 in ARMING or ARMED sets a pending flag. The state goes to DISARMED at the next boundary so no pulse is truncated.
- disarm and arm in the same cycle: disarm wins.
- arm while in ARMING or ARMED is ignored.
- disarm while DISARMED is a no-op.
- motors_off does not change state; it forces speed 0 from the next frame.
- rst mid-frame: every output drops to its reset value on the next edge. A truncated pulse is acceptable on reset only.

Optional Feature:
ESC_SLEW_EN. When defined, at each boundary applied_i moves toward spd_i by at most SLEW_STEP, and exactly reaches spd_i when the difference is <= SLEW_STEP. motors_off, ARMING and DISARMED still force applied_i=0 immediately, with no slew on the way down for safety. When undefined, applied_i = spd_i at every boundary and SLEW_STEP is unused.

Test Plan:
- Reset, no arm, run 3 frames -> pwm stays 0, armed=0; frame_strt pulses every 125000 cycles.
- arm pulse, spd all = 100 -> 8 frames of 50000-cycle pulses, then armed=1. Next frame pulses are 50000+1600=51600 cycles on all 4 channels.
- ARMED, spd ch0=2047, ch1=0 -> ch0 pulse 82752 cycles, ch1 50000. spd changed at cnt=60000 -> current frame unchanged, new width from the next frame_strt.
- ARMED, motors_off raised mid-frame -> current frame unchanged, next frame all channels 50000; armed stays 1.
- arm and disarm in the same cycle while DISARMED -> stays DISARMED. disarm at cnt=10000 while ARMED -> current pulse completes, pwm=0 from the next frame, armed=0.
- ESC_SLEW_EN, SLEW_STEP=64, spd 0 -> 200 -> applied 64, 128, 192, 200 over 4 frames (pulses 51024, 52048, 53072, 53200). Then motors_off -> 50000 in the next frame.
